// File: rtl/spi_shift_eng_if.sv
// ---------------------------------------------------------------------------
// spi_shift_eng_if
// Bundles the host-side byte handshake, the per-transfer configuration and
// the SPI pins of spi_shift_eng into one interface.
//   master modport : the host/bench side (drives cfg, tx, spi_miso)
//   slave  modport : the shift engine (drives tx_ready, rx, busy, SPI pins)
// Signals:
//   cfg_div   [div_w]  SCK half-period minus one, in clk cycles
//   cfg_cpol  [1]      SCK idle level
//   cfg_cpha  [1]      0 = sample on leading edge, 1 = sample on trailing edge
//   cs_mask   [cs_w]   slaves to select for the next transfer
//   tx_data   [8]      byte to transmit, tx_valid qualifies it
//   tx_ready  [1]      engine can accept a byte
//   rx_data   [8]      last received byte, rx_valid pulses for one cycle
//   busy      [1]      transfer in progress
//   spi_mosi, spi_miso, spi_sck, spi_cs[cs_w] (active-low)
// ---------------------------------------------------------------------------
interface spi_shift_eng_if #(
  parameter int cs_w  = 8,
  parameter int div_w = 8
);
  logic [div_w-1:0] cfg_div;
  logic             cfg_cpol;
  logic             cfg_cpha;
  logic [cs_w-1:0]  cs_mask;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             busy;
  logic             spi_mosi;
  logic             spi_miso;
  logic             spi_sck;
  logic [cs_w-1:0]  spi_cs;

  modport master (
    output cfg_div, cfg_cpol, cfg_cpha, cs_mask, tx_data, tx_valid, spi_miso,
    input  tx_ready, rx_data, rx_valid, busy, spi_mosi, spi_sck, spi_cs
  );

  modport slave (
    input  cfg_div, cfg_cpol, cfg_cpha, cs_mask, tx_data, tx_valid, spi_miso,
    output tx_ready, rx_data, rx_valid, busy, spi_mosi, spi_sck, spi_cs
  );
endinterface

// File: rtl/spi_shift_eng.sv
// ---------------------------------------------------------------------------
// spi_shift_eng
// Single-byte SPI master shift engine. A tx_valid/tx_ready handshake latches
// the byte and the whole configuration; the engine then clocks 8 bits out on
// spi_mosi while capturing spi_miso, holds CS for one extra half-period, and
// returns the received byte with a one-cycle rx_valid pulse.
// Ports:
//   clk   : clock, rising edge
//   rstn  : asynchronous active-low reset
//   bus   : spi_shift_eng_if.slave (handshake, config and SPI pins)
// Configuration macro:
//   SPI_SHIFT_LSB_FIRST_EN : when defined, bit 0 is shifted/received first;
//                            otherwise MSB-first. Timing is identical.
// ---------------------------------------------------------------------------
module spi_shift_eng #(
  parameter int cs_w  = 8,
  parameter int div_w = 8
) (
  input logic           clk,
  input logic           rstn,
  spi_shift_eng_if.slave bus
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t           state_q;
  logic [div_w-1:0] div_q;
  logic [div_w-1:0] divCfg_q;
  logic             cpol_q;
  logic             cpha_q;
  logic [3:0]       edge_q;
  logic [7:0]       txSh_q;
  logic [7:0]       rxSh_q;
  logic [7:0]       rxData_q;
  logic             rxValid_q;
  logic             sck_q;
  logic             mosi_q;
  logic [cs_w-1:0]  cs_q;

  logic             divWrap_d;
  logic             sampleEdge_d;
  logic             hsBit_d;
  logic [7:0]       hsRest_d;
  logic             txBit_d;
  logic [7:0]       txNext_d;
  logic [7:0]       rxNext_d;

  // Bit-order selection: the only place MSB/LSB-first differ.
  always_comb begin
`ifdef SPI_SHIFT_LSB_FIRST_EN
    hsBit_d  = bus.tx_data[0];
    hsRest_d = {1'b0, bus.tx_data[7:1]};
    txBit_d  = txSh_q[0];
    txNext_d = {1'b0, txSh_q[7:1]};
    rxNext_d = {bus.spi_miso, rxSh_q[7:1]};
`else
    hsBit_d  = bus.tx_data[7];
    hsRest_d = {bus.tx_data[6:0], 1'b0};
    txBit_d  = txSh_q[7];
    txNext_d = {txSh_q[6:0], 1'b0};
    rxNext_d = {rxSh_q[6:0], bus.spi_miso};
`endif
  end

  // Divider wraps by comparison, so D = 2^div_w-1 never overflows.
  // Even edge_q is a leading edge; CPHA=0 samples there, CPHA=1 on odd ones.
  assign divWrap_d    = (div_q == divCfg_q);
  assign sampleEdge_d = (edge_q[0] == cpha_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      div_q     <= '0;
      divCfg_q  <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      edge_q    <= '0;
      txSh_q    <= '0;
      rxSh_q    <= '0;
      rxData_q  <= '0;
      rxValid_q <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      cs_q      <= '1;
    end else begin
      rxValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sck_q <= bus.cfg_cpol;
          if (bus.tx_valid) begin
            divCfg_q <= bus.cfg_div;
            cpol_q   <= bus.cfg_cpol;
            cpha_q   <= bus.cfg_cpha;
            cs_q     <= ~bus.cs_mask;
            div_q    <= '0;
            edge_q   <= '0;
            rxSh_q   <= '0;
            // CPHA=0 needs the first bit on the wire before the first edge;
            // CPHA=1 drives it on the first (leading) edge instead.
            if (!bus.cfg_cpha) begin
              mosi_q <= hsBit_d;
              txSh_q <= hsRest_d;
            end else begin
              txSh_q <= bus.tx_data;
            end
            state_q <= XFER;
          end
        end
        XFER: begin
          if (divWrap_d) begin
            div_q  <= '0;
            sck_q  <= ~sck_q;
            edge_q <= edge_q + 4'd1;
            if (sampleEdge_d) begin
              rxSh_q <= rxNext_d;
            end else if (cpha_q || edge_q != 4'd15) begin
              // The last CPHA=0 trailing edge has no further bit to present.
              mosi_q <= txBit_d;
              txSh_q <= txNext_d;
            end
            if (edge_q == 4'd15) begin
              state_q <= DONE;
            end
          end else begin
            div_q <= div_q + div_w'(1);
          end
        end
        DONE: begin
          if (divWrap_d) begin
            div_q     <= '0;
            cs_q      <= '1;
            sck_q     <= bus.cfg_cpol;
            rxData_q  <= rxSh_q;
            rxValid_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            div_q <= div_q + div_w'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_ready = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.rx_data  = rxData_q;
  assign bus.rx_valid = rxValid_q;
  assign bus.spi_sck  = sck_q;
  assign bus.spi_mosi = mosi_q;
  assign bus.spi_cs   = cs_q;

endmodule

// File: tb/tb_spi_shift_eng.sv
// ---------------------------------------------------------------------------
// tb_spi_shift_eng
// Self-checking bench for spi_shift_eng. Expected received bytes are queued
// when a transfer is started and compared when rx_valid pulses. Cycle index
// k = 1 denotes the first cycle after the handshake edge.
// ---------------------------------------------------------------------------
module tb_spi_shift_eng;
  localparam int CS_W  = 8;
  localparam int DIV_W = 8;

  logic clk = 1'b0;
  logic rstn;
  logic loopEn  = 1'b1;
  logic misoTie = 1'b0;

  int testsRun    = 0;
  int testsFailed = 0;
  logic [7:0] expQ[$];

  always #5 clk = ~clk;

  spi_shift_eng_if #(.cs_w(CS_W), .div_w(DIV_W)) bus ();

  spi_shift_eng #(.cs_w(CS_W), .div_w(DIV_W)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  assign bus.spi_miso = loopEn ? bus.spi_mosi : misoTie;

  // Bit i (in shift order) of a byte as the engine should put it on MOSI.
  function automatic logic txBitAt(input logic [7:0] d, input int i);
`ifdef SPI_SHIFT_LSB_FIRST_EN
    return d[i];
`else
    return d[7-i];
`endif
  endfunction

  // Drives one handshake; returns at the falling edge of cycle N+1.
  task automatic start_xfer(input logic [7:0] data, input logic [7:0] div,
                            input logic cpol, input logic cpha,
                            input logic [7:0] mask);
    bit got;
    got = 0;
    @(negedge clk);
    bus.cfg_div  = div;
    bus.cfg_cpol = cpol;
    bus.cfg_cpha = cpha;
    bus.cs_mask  = mask;
    bus.tx_data  = data;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.tx_ready) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.tx_valid = 1'b0;
    testsRun++;
    if (!got) begin
      testsFailed++;
      $display("[TB] FAIL handshake_timeout tx_ready never seen for %h", data);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.cfg_div = '0; bus.cfg_cpol = 1'b0; bus.cfg_cpha = 1'b0;
    bus.cs_mask = '0; bus.tx_data = '0; bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    testsRun++;
    if (bus.spi_cs !== 8'hFF) begin testsFailed++; $display("[TB] FAIL reset_cs got %h want ff", bus.spi_cs); end
    testsRun++;
    if (bus.spi_sck !== 1'b0 || bus.spi_mosi !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_pins got sck=%b mosi=%b want 0/0", bus.spi_sck, bus.spi_mosi); end
    testsRun++;
    if (bus.rx_data !== 8'h00 || bus.rx_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rx got %h/%b want 00/0", bus.rx_data, bus.rx_valid); end
    testsRun++;
    if (bus.tx_ready !== 1'b1 || bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ready got rdy=%b busy=%b want 1/0", bus.tx_ready, bus.busy); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int rxK;
    logic [7:0] exp;
    rxK = -1;
    loopEn = 1'b1;
    expQ.push_back(8'hA5);
    start_xfer(8'hA5, 8'd1, 1'b0, 1'b0, 8'h01);
    for (int k = 1; k <= 45; k++) begin
      if (k <= 29 && (k - 1) % 4 == 0) begin
        testsRun++;
        if (bus.spi_mosi !== txBitAt(8'hA5, (k - 1) / 4)) begin testsFailed++; $display("[TB] FAIL basic_mosi bit%0d got %b want %b", (k - 1) / 4, bus.spi_mosi, txBitAt(8'hA5, (k - 1) / 4)); end
      end
      if (k == 2) begin
        testsRun++;
        if (bus.spi_cs !== 8'hFE || bus.busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_cs got cs=%h busy=%b want fe/1", bus.spi_cs, bus.busy); end
      end
      if (bus.rx_valid) begin
        if (rxK < 0) rxK = k;
        testsRun++;
        if (expQ.size() == 0) begin testsFailed++; $display("[TB] FAIL basic_rx unexpected rx_valid got %h", bus.rx_data); end
        else begin
          exp = expQ.pop_front();
          if (bus.rx_data !== exp || bus.spi_cs !== 8'hFF) begin testsFailed++; $display("[TB] FAIL basic_rx got %h cs=%h want %h cs=ff", bus.rx_data, bus.spi_cs, exp); end
        end
      end
      @(negedge clk);
    end
    testsRun++;
    if (rxK != 35) begin testsFailed++; $display("[TB] FAIL basic_latency got %0d want 35", rxK); end
  endtask

  task automatic test_cpha1();
    int rxK, toggles;
    logic prevSck;
    logic [7:0] exp;
    rxK = -1; toggles = 0;
    loopEn = 1'b0; misoTie = 1'b1;
    @(negedge clk);
    bus.cfg_cpol = 1'b1;
    repeat (2) @(negedge clk);
    testsRun++;
    if (bus.spi_sck !== 1'b1) begin testsFailed++; $display("[TB] FAIL cpha1_idle_sck got %b want 1", bus.spi_sck); end
    expQ.push_back(8'hFF);
    start_xfer(8'h3C, 8'd0, 1'b1, 1'b1, 8'h01);
    prevSck = bus.spi_sck;
    for (int k = 1; k <= 25; k++) begin
      if (k >= 2 && k <= 17) begin
        if (bus.spi_sck !== prevSck) toggles++;
      end
      prevSck = bus.spi_sck;
      if (k >= 2 && k <= 16 && k % 2 == 0) begin
        testsRun++;
        if (bus.spi_mosi !== txBitAt(8'h3C, (k - 2) / 2)) begin testsFailed++; $display("[TB] FAIL cpha1_mosi bit%0d got %b want %b", (k - 2) / 2, bus.spi_mosi, txBitAt(8'h3C, (k - 2) / 2)); end
      end
      if (k == 17) begin
        testsRun++;
        if (bus.spi_sck !== 1'b1) begin testsFailed++; $display("[TB] FAIL cpha1_done_sck got %b want 1", bus.spi_sck); end
      end
      if (bus.rx_valid) begin
        if (rxK < 0) rxK = k;
        testsRun++;
        if (expQ.size() == 0) begin testsFailed++; $display("[TB] FAIL cpha1_rx unexpected rx_valid got %h", bus.rx_data); end
        else begin
          exp = expQ.pop_front();
          if (bus.rx_data !== exp) begin testsFailed++; $display("[TB] FAIL cpha1_rx got %h want %h", bus.rx_data, exp); end
        end
      end
      @(negedge clk);
    end
    testsRun++;
    if (toggles != 16) begin testsFailed++; $display("[TB] FAIL cpha1_edges got %0d want 16", toggles); end
    testsRun++;
    if (rxK != 18) begin testsFailed++; $display("[TB] FAIL cpha1_latency got %0d want 18", rxK); end
  endtask

  task automatic test_back_to_back();
    int accepted, rxCnt, csHigh;
    bit pending;
    logic [7:0] exp;
    accepted = 0; rxCnt = 0; csHigh = 0; pending = 0;
    loopEn = 1'b1;
    expQ.push_back(8'h11);
    expQ.push_back(8'h22);
    @(negedge clk);
    bus.cfg_div = 8'd1; bus.cfg_cpol = 1'b0; bus.cfg_cpha = 1'b0;
    bus.cs_mask = 8'h04; bus.tx_data = 8'h11; bus.tx_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (pending) begin
        accepted++;
        pending = 0;
        if (accepted == 1) begin
          bus.tx_data = 8'h22;
          testsRun++;
          if (bus.spi_cs !== 8'hFB) begin testsFailed++; $display("[TB] FAIL b2b_cs got %h want fb", bus.spi_cs); end
        end else begin
          bus.tx_valid = 1'b0;
        end
      end
      if (bus.rx_valid) begin
        rxCnt++;
        testsRun++;
        if (expQ.size() == 0) begin testsFailed++; $display("[TB] FAIL b2b_rx unexpected rx_valid got %h", bus.rx_data); end
        else begin
          exp = expQ.pop_front();
          if (bus.rx_data !== exp) begin testsFailed++; $display("[TB] FAIL b2b_rx got %h want %h", bus.rx_data, exp); end
        end
        if (rxCnt == 1) begin
          testsRun++;
          if (bus.tx_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_ready got %b want 1", bus.tx_ready); end
        end
      end
      if (accepted >= 1 && rxCnt < 2 && bus.spi_cs[2] === 1'b1) csHigh++;
      if (bus.tx_valid && bus.tx_ready) pending = 1;
      @(negedge clk);
    end
    bus.tx_valid = 1'b0;
    testsRun++;
    if (rxCnt != 2) begin testsFailed++; $display("[TB] FAIL b2b_pulses got %0d want 2", rxCnt); end
    testsRun++;
    if (csHigh != 1) begin testsFailed++; $display("[TB] FAIL b2b_cs_gap got %0d want 1", csHigh); end
  endtask

  task automatic test_hold_valid();
    int rxK1, rxK2, earlyReady;
    logic [7:0] exp;
    rxK1 = -1; rxK2 = -1; earlyReady = 0;
    loopEn = 1'b1;
    expQ.push_back(8'h5A);
    expQ.push_back(8'hC3);
    @(negedge clk);
    bus.cfg_div = 8'd3; bus.cfg_cpol = 1'b0; bus.cfg_cpha = 1'b0;
    bus.cs_mask = 8'h01; bus.tx_data = 8'h5A; bus.tx_valid = 1'b1;
    testsRun++;
    if (bus.tx_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL hold_pre_ready got %b want 1", bus.tx_ready); end
    @(negedge clk);
    bus.cfg_div = 8'd0;
    bus.tx_data = 8'hC3;
    for (int k = 1; k <= 100; k++) begin
      if (k <= 68 && bus.tx_ready) earlyReady++;
      if (k == 70) bus.tx_valid = 1'b0;
      if (bus.rx_valid) begin
        if (rxK1 < 0) rxK1 = k; else if (rxK2 < 0) rxK2 = k;
        testsRun++;
        if (expQ.size() == 0) begin testsFailed++; $display("[TB] FAIL hold_rx unexpected rx_valid got %h", bus.rx_data); end
        else begin
          exp = expQ.pop_front();
          if (bus.rx_data !== exp) begin testsFailed++; $display("[TB] FAIL hold_rx got %h want %h", bus.rx_data, exp); end
        end
      end
      @(negedge clk);
    end
    testsRun++;
    if (earlyReady != 0) begin testsFailed++; $display("[TB] FAIL hold_early_ready got %0d cycles want 0", earlyReady); end
    testsRun++;
    if (rxK1 != 69) begin testsFailed++; $display("[TB] FAIL hold_first_latency got %0d want 69", rxK1); end
    testsRun++;
    if (rxK2 != 87) begin testsFailed++; $display("[TB] FAIL hold_second_latency got %0d want 87", rxK2); end
  endtask

  task automatic test_reset_mid();
    int rxK, stray;
    logic [7:0] exp;
    rxK = -1; stray = 0;
    loopEn = 1'b1;
    start_xfer(8'h96, 8'd1, 1'b0, 1'b0, 8'hFF);
    repeat (17) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    testsRun++;
    if (bus.spi_cs !== 8'hFF || bus.spi_sck !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_async got cs=%h sck=%b want ff/0", bus.spi_cs, bus.spi_sck); end
    testsRun++;
    if (bus.busy !== 1'b0 || bus.rx_valid !== 1'b0 || bus.spi_mosi !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_state got busy=%b rxv=%b mosi=%b want 0/0/0", bus.busy, bus.rx_valid, bus.spi_mosi); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (bus.rx_valid) stray++;
      @(negedge clk);
    end
    testsRun++;
    if (stray != 0) begin testsFailed++; $display("[TB] FAIL abort_no_rx got %0d pulses want 0", stray); end
    expQ.push_back(8'h69);
    start_xfer(8'h69, 8'd2, 1'b0, 1'b0, 8'h0F);
    for (int k = 1; k <= 60; k++) begin
      if (k == 2) begin
        testsRun++;
        if (bus.spi_cs !== 8'hF0) begin testsFailed++; $display("[TB] FAIL after_abort_cs got %h want f0", bus.spi_cs); end
      end
      if (bus.rx_valid) begin
        if (rxK < 0) rxK = k;
        testsRun++;
        if (expQ.size() == 0) begin testsFailed++; $display("[TB] FAIL after_abort_rx unexpected rx_valid got %h", bus.rx_data); end
        else begin
          exp = expQ.pop_front();
          if (bus.rx_data !== exp) begin testsFailed++; $display("[TB] FAIL after_abort_rx got %h want %h", bus.rx_data, exp); end
        end
      end
      @(negedge clk);
    end
    testsRun++;
    if (rxK != 52) begin testsFailed++; $display("[TB] FAIL after_abort_latency got %0d want 52", rxK); end
  endtask

  task automatic test_bit_order();
    int rxK;
    logic [7:0] exp;
    rxK = -1;
    loopEn = 1'b1;
    expQ.push_back(8'h01);
    start_xfer(8'h01, 8'd0, 1'b0, 1'b0, 8'h02);
    for (int k = 1; k <= 25; k++) begin
      if (k <= 15 && (k - 1) % 2 == 0) begin
        testsRun++;
        if (bus.spi_mosi !== txBitAt(8'h01, (k - 1) / 2)) begin testsFailed++; $display("[TB] FAIL order_mosi bit%0d got %b want %b", (k - 1) / 2, bus.spi_mosi, txBitAt(8'h01, (k - 1) / 2)); end
      end
      if (bus.rx_valid) begin
        if (rxK < 0) rxK = k;
        testsRun++;
        if (expQ.size() == 0) begin testsFailed++; $display("[TB] FAIL order_rx unexpected rx_valid got %h", bus.rx_data); end
        else begin
          exp = expQ.pop_front();
          if (bus.rx_data !== exp) begin testsFailed++; $display("[TB] FAIL order_rx got %h want %h", bus.rx_data, exp); end
        end
      end
      @(negedge clk);
    end
    testsRun++;
    if (rxK != 18) begin testsFailed++; $display("[TB] FAIL order_latency got %0d want 18", rxK); end
  endtask

  task automatic test_max_div();
    int rxK;
    logic [7:0] exp;
    rxK = -1;
    loopEn = 1'b0; misoTie = 1'b0;
    expQ.push_back(8'h00);
    start_xfer(8'hFF, 8'd255, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= 4400; k++) begin
      if (k == 2) begin
        testsRun++;
        if (bus.spi_cs !== 8'hFF || bus.busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL maxdiv_nocs got cs=%h busy=%b want ff/1", bus.spi_cs, bus.busy); end
      end
      if (k == 256 || k == 257) begin
        testsRun++;
        if (bus.spi_sck !== (k == 257)) begin testsFailed++; $display("[TB] FAIL maxdiv_sck k=%0d got %b want %b", k, bus.spi_sck, (k == 257)); end
      end
      if (bus.rx_valid) begin
        if (rxK < 0) rxK = k;
        testsRun++;
        if (expQ.size() == 0) begin testsFailed++; $display("[TB] FAIL maxdiv_rx unexpected rx_valid got %h", bus.rx_data); end
        else begin
          exp = expQ.pop_front();
          if (bus.rx_data !== exp) begin testsFailed++; $display("[TB] FAIL maxdiv_rx got %h want %h", bus.rx_data, exp); end
        end
      end
      @(negedge clk);
    end
    testsRun++;
    if (rxK != 4353) begin testsFailed++; $display("[TB] FAIL maxdiv_latency got %0d want 4353", rxK); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cpha1();
    test_back_to_back();
    test_hold_valid();
    test_reset_mid();
    test_bit_order();
    test_max_div();
    testsRun++;
    if (expQ.size() != 0) begin testsFailed++; $display("[TB] FAIL scoreboard_leftover got %0d entries want 0", expQ.size()); end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
